// File: rtl/i2c_master_wr_pkg.sv
// i2c_pkg: state encoding, quarter-phase constants and the per-quarter
// SCL/SDA drive table shared by the I2C write master.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_ADDR  = 3'd2,
      ST_AACK  = 3'd3,
      ST_DATA  = 3'd4,
      ST_DACK  = 3'd5,
      ST_STOP  = 3'd6,
      ST_WAIT  = 3'd7
   } state_e;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   localparam logic I2C_WRITE = 1'b0;

   // {scl, sda_oe} for a state/quarter; bit_v is the bit being shifted out
   function automatic logic [1:0] quarter_out(input state_e st, input logic [1:0] ph,
                                              input logic bit_v);
      logic [1:0] r;
      r = 2'b10;
      case (st)
         ST_START:         r = {1'b1, (ph == Q2) || (ph == Q3)};
         ST_ADDR, ST_DATA: r = {ph[1], ~bit_v};
         ST_AACK, ST_DACK: r = {ph[1], 1'b0};
         ST_STOP:          r = {ph != Q0, (ph == Q0) || (ph == Q1)};
         ST_WAIT:          r = 2'b00;
         default:          r = 2'b10;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/i2c_master_wr_if.sv
// Request stream and pad signals of the I2C write master.
// master: the engine itself; slave: the sequencer/pad side driving it.
interface i2c_master_wr_if;
   import i2c_pkg::*;

   logic       start;
   logic [6:0] dev_addr;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_valid;
   logic       tx_ready;
   logic       scl_o;
   logic       sda_oe;
   logic       sda_i;
   logic       busy;
   logic       done;
   logic       nack;

   modport master (
      input  start, dev_addr, tx_data, tx_last, tx_valid, sda_i,
      output tx_ready, scl_o, sda_oe, busy, done, nack
   );

   modport slave (
      output start, dev_addr, tx_data, tx_last, tx_valid, sda_i,
      input  tx_ready, scl_o, sda_oe, busy, done, nack
   );

endinterface

// File: rtl/i2c_master_wr_tick_gen.sv
// i2c_tick_gen: quarter-SCL-period strobe, one clk every CLK_DIV clks while en_i.
// The counter is held at zero whenever en_i is low so each quarter starts fresh.
module i2c_tick_gen #(
   parameter int CLK_DIV = 4,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   assign tick_o = en_i && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst || !en_i) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_master_wr.sv
// i2c_master_wr: write-only I2C master. START, address+W, bytes from a
// valid/ready stream, STOP; open-drain SDA and SCL derived from clk.
module i2c_master_wr
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int CNT_W   = 8
) (
   input  logic            clk,
   input  logic            rst,
   i2c_master_wr_if.master bus
);

   state_e     state_q;
   logic [1:0] phase_q;
   logic [2:0] bit_q;
   logic [7:0] shift_q;
   logic       last_q;
   logic       ack_nack_q;
   logic       scl_q;
   logic       sda_oe_q;
   logic       busy_q;
   logic       done_q;
   logic       nack_q;
   logic       tx_ready_q;
   logic       tick_en_s;
   logic       tick_s;

   // The divider is frozen while waiting for a byte, which holds SCL low
   assign tick_en_s = busy_q && (state_q != ST_WAIT);

   i2c_tick_gen #(
      .CLK_DIV (CLK_DIV),
      .CNT_W   (CNT_W)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .en_i   (tick_en_s),
      .tick_o (tick_s)
   );

   assign bus.scl_o    = scl_q;
   assign bus.sda_oe   = sda_oe_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.nack     = nack_q;
   assign bus.tx_ready = tx_ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         phase_q    <= Q0;
         bit_q      <= 3'd0;
         shift_q    <= 8'h00;
         last_q     <= 1'b0;
         ack_nack_q <= 1'b0;
         scl_q      <= 1'b1;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         nack_q     <= 1'b0;
         tx_ready_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         tx_ready_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q           <= ST_START;
                  phase_q           <= Q0;
                  shift_q           <= {bus.dev_addr, I2C_WRITE};
                  last_q            <= 1'b0;
                  busy_q            <= 1'b1;
                  nack_q            <= 1'b0;
                  {scl_q, sda_oe_q} <= quarter_out(ST_START, Q0, 1'b0);
               end
            end
            ST_WAIT: begin
               if (bus.tx_valid) begin
                  tx_ready_q        <= 1'b1;
                  shift_q           <= bus.tx_data;
                  last_q            <= bus.tx_last;
                  bit_q             <= 3'd7;
                  phase_q           <= Q0;
                  state_q           <= ST_DATA;
                  {scl_q, sda_oe_q} <= quarter_out(ST_DATA, Q0, bus.tx_data[7]);
               end
            end
            default: begin
               if (tick_s && (phase_q != Q3)) begin
                  phase_q           <= phase_q + 2'd1;
                  {scl_q, sda_oe_q} <= quarter_out(state_q, phase_q + 2'd1, shift_q[7]);
                  if ((phase_q == Q2) && ((state_q == ST_AACK) || (state_q == ST_DACK))) begin
                     ack_nack_q <= bus.sda_i;
                  end
               end else if (tick_s) begin
                  phase_q <= Q0;
                  case (state_q)
                     ST_START: begin
                        state_q           <= ST_ADDR;
                        bit_q             <= 3'd7;
                        {scl_q, sda_oe_q} <= quarter_out(ST_ADDR, Q0, shift_q[7]);
                     end
                     ST_ADDR, ST_DATA: begin
                        if (bit_q == 3'd0) begin
                           state_q           <= (state_q == ST_ADDR) ? ST_AACK : ST_DACK;
                           {scl_q, sda_oe_q} <= quarter_out(ST_AACK, Q0, 1'b0);
                        end else begin
                           bit_q             <= bit_q - 3'd1;
                           shift_q           <= {shift_q[6:0], 1'b0};
                           {scl_q, sda_oe_q} <= quarter_out(state_q, Q0, shift_q[6]);
                        end
                     end
                     ST_AACK, ST_DACK: begin
                        if (ack_nack_q || ((state_q == ST_DACK) && last_q)) begin
                           nack_q            <= ack_nack_q;
                           state_q           <= ST_STOP;
                           {scl_q, sda_oe_q} <= quarter_out(ST_STOP, Q0, 1'b0);
                        end else if (bus.tx_valid) begin
                           tx_ready_q        <= 1'b1;
                           shift_q           <= bus.tx_data;
                           last_q            <= bus.tx_last;
                           bit_q             <= 3'd7;
                           state_q           <= ST_DATA;
                           {scl_q, sda_oe_q} <= quarter_out(ST_DATA, Q0, bus.tx_data[7]);
                        end else begin
                           state_q           <= ST_WAIT;
                           {scl_q, sda_oe_q} <= quarter_out(ST_WAIT, Q0, 1'b0);
                        end
                     end
                     ST_STOP: begin
                        state_q           <= ST_IDLE;
                        busy_q            <= 1'b0;
                        done_q            <= 1'b1;
                        {scl_q, sda_oe_q} <= quarter_out(ST_IDLE, Q0, 1'b0);
                     end
                     default: begin
                        state_q <= ST_IDLE;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: a bus-level I2C slave/monitor decodes bytes, ACK
// slots, START/STOP and SCL timing; transactions are checked against the rules.
module tb_i2c_master_wr;

   localparam int CLK_DIV = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   i2c_master_wr_if bus ();

   i2c_master_wr #(.CLK_DIV(CLK_DIV), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Slave model and bus monitor
   logic       slave_pull = 1'b0;
   logic       sda_line;
   logic       scl_p = 1'b1;
   logic       sda_p = 1'b1;
   int         bitcnt = 0;
   int         nbytes = 0;
   logic [7:0] cur_b = 8'h00;
   logic [7:0] bytes_q[$];
   logic       acks_q[$];
   int         n_start = 0;
   int         n_stop = 0;
   int         n_rise = 0;
   int         bad_period = 0;
   int         cyc = 0;
   int         last_rise = 0;
   int         nack_slot = -1;
   logic [7:0] data_a[5];

   assign sda_line  = !(bus.sda_oe || slave_pull);
   assign bus.sda_i = sda_line;

   always @(negedge clk) begin
      cyc   <= cyc + 1;
      scl_p <= bus.scl_o;
      sda_p <= sda_line;
      if (bus.scl_o && scl_p && sda_p && !sda_line) begin
         n_start <= n_start + 1;
         bitcnt  <= 0;
         nbytes  <= 0;
      end else if (bus.scl_o && scl_p && !sda_p && sda_line) begin
         n_stop <= n_stop + 1;
      end else if (bus.scl_o && !scl_p) begin
         n_rise    <= n_rise + 1;
         last_rise <= cyc;
         if (bitcnt >= 1 && bitcnt <= 7 && (cyc - last_rise) != 4 * CLK_DIV)
            bad_period <= bad_period + 1;
         if (bitcnt == 8) begin
            acks_q.push_back(sda_line);
            bitcnt <= 0;
         end else begin
            cur_b  <= {cur_b[6:0], sda_line};
            bitcnt <= bitcnt + 1;
            if (bitcnt == 7) begin
               bytes_q.push_back({cur_b[6:0], sda_line});
               nbytes <= nbytes + 1;
            end
         end
      end else if (!bus.scl_o && scl_p) begin
         slave_pull <= (bitcnt == 8) && ((nbytes - 1) != nack_slot);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one transaction as the sequencer and collect handshake statistics
   task automatic run_txn(input logic [6:0] addr, input int n, input int stall_until,
                          input int busy_start_at, output int n_ready, output int n_done,
                          output int busy_gap, output int stall_viol, output logic nack_done,
                          output logic nack_t0, output logic timed_out);
      int idx = 0;
      int post = 0;
      n_ready = 0; n_done = 0; busy_gap = 0; stall_viol = 0;
      nack_done = 1'b0; nack_t0 = 1'b1; timed_out = 1'b1;
      @(negedge clk);
      bus.dev_addr = addr;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.dev_addr = ~addr;
      nack_t0      = bus.nack;
      for (int t = 0; t < 4000; t++) begin
         if (bus.tx_ready) begin
            n_ready++;
            idx++;
         end
         if (bus.done) begin
            n_done++;
            nack_done = bus.nack;
            timed_out = 1'b0;
         end
         if (!bus.busy && n_done == 0) busy_gap++;
         if (n_done > 0) post++;
         if (post > 6) break;
         if (stall_until > 0 && t >= stall_until - 40 && t < stall_until &&
             (bus.scl_o !== 1'b0 || bus.sda_oe !== 1'b0))
            stall_viol++;
         bus.start    = (t == busy_start_at);
         bus.dev_addr = (t == busy_start_at) ? (addr ^ 7'h55) : ~addr;
         bus.tx_valid = (idx < n) && (t >= stall_until);
         bus.tx_data  = data_a[idx];
         bus.tx_last  = (idx == n - 1);
         @(negedge clk);
      end
      bus.start    = 1'b0;
      bus.tx_valid = 1'b0;
   endtask

   // Reference: address slot is 0, data byte i is slot i+1; a NACK at slot s ends
   // the transfer after s data bytes, so exactly those bytes are requested
   task automatic run_and_check(input string tg, input logic [6:0] addr, input int n,
                                input int nslot, input int stall_until, input int busy_start_at);
      int b0 = bytes_q.size();
      int a0 = acks_q.size();
      int s0 = n_start;
      int p0 = n_stop;
      int r0 = n_rise;
      int bp0 = bad_period;
      int sent = (nslot < 0) ? n : nslot;
      int n_ready, n_done, busy_gap, stall_viol;
      logic nack_done, nack_t0, timed_out;
      logic [7:0] exp_b;
      nack_slot = nslot;
      run_txn(addr, n, stall_until, busy_start_at, n_ready, n_done, busy_gap, stall_viol,
              nack_done, nack_t0, timed_out);
      chk({tg, "_timeout"}, 32'(timed_out), 32'd0);
      chk({tg, "_tx_ready_cnt"}, n_ready, sent);
      chk({tg, "_done_cnt"}, n_done, 32'd1);
      chk({tg, "_busy_gap"}, busy_gap, 32'd0);
      chk({tg, "_nack_start"}, 32'(nack_t0), 32'd0);
      chk({tg, "_nack_done"}, 32'(nack_done), 32'(nslot >= 0));
      chk({tg, "_nack_hold"}, 32'(bus.nack), 32'(nslot >= 0));
      chk({tg, "_byte_cnt"}, bytes_q.size() - b0, sent + 1);
      for (int i = 0; i <= sent && b0 + i < bytes_q.size(); i++) begin
         exp_b = (i == 0) ? {addr, 1'b0} : data_a[i-1];
         chk($sformatf("%s_byte%0d", tg, i), 32'(bytes_q[b0+i]), 32'(exp_b));
      end
      chk({tg, "_ack_cnt"}, acks_q.size() - a0, sent + 1);
      for (int j = 0; j <= sent && a0 + j < acks_q.size(); j++)
         chk($sformatf("%s_ack%0d", tg, j), 32'(acks_q[a0+j]), 32'(j == nslot));
      chk({tg, "_starts"}, n_start - s0, 32'd1);
      chk({tg, "_stops"}, n_stop - p0, 32'd1);
      chk({tg, "_scl_rises"}, n_rise - r0, 9 * (sent + 1) + 1);
      chk({tg, "_scl_period"}, bad_period - bp0, 32'd0);
      chk({tg, "_stall"}, stall_viol, 32'd0);
   endtask

   initial begin
      int   n, r, s0, done_cnt;
      logic hit;
      bus.start = 1'b0; bus.dev_addr = 7'h00; bus.tx_data = 8'h00;
      bus.tx_last = 1'b0; bus.tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_scl", 32'(bus.scl_o), 32'd1);
      chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_nack", 32'(bus.nack), 32'd0);
      chk("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      data_a[0] = 8'hAA;
      run_and_check("t1", 7'h50, 1, -1, 0, -1);
      data_a[0] = 8'h01; data_a[1] = 8'h02; data_a[2] = 8'h03;
      run_and_check("t2", 7'h3C, 3, -1, 0, 100);
      data_a[0] = 8'hAA;
      run_and_check("t3", 7'h50, 1, 0, 0, -1);
      data_a[0] = 8'h11; data_a[1] = 8'h22; data_a[2] = 8'h33;
      run_and_check("t4", 7'h50, 3, 2, 0, -1);
      data_a[0] = 8'h5A; data_a[1] = 8'hC3;
      run_and_check("t5", 7'h21, 2, -1, 230, -1);

      // Reset in the middle of data bit 3
      nack_slot = -1;
      s0 = n_stop;
      hit = 1'b0;
      @(negedge clk);
      bus.dev_addr = 7'h50; bus.start = 1'b1;
      bus.tx_data = 8'hAA; bus.tx_last = 1'b1; bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int t = 0; t < 2000 && !hit; t++) begin
         if (bus.tx_ready) bus.tx_valid = 1'b0;
         if (nbytes == 1 && bitcnt == 4) hit = 1'b1;
         else @(negedge clk);
      end
      bus.tx_valid = 1'b0;
      chk("t6_reach_bit3", 32'(hit), 32'd1);
      repeat (11) @(negedge clk);
      chk("t6_pre_scl", 32'(bus.scl_o), 32'd0);
      chk("t6_pre_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_scl", 32'(bus.scl_o), 32'd1);
      chk("t6_sda_oe", 32'(bus.sda_oe), 32'd0);
      chk("t6_busy", 32'(bus.busy), 32'd0);
      chk("t6_done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      done_cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
      end
      chk("t6_no_done", done_cnt, 32'd0);
      chk("t6_no_stop", n_stop - s0, 32'd0);
      data_a[0] = 8'hAA;
      run_and_check("t6b", 7'h50, 1, -1, 0, -1);

      for (int k = 0; k < 5; k++) begin
         n = $urandom_range(1, 4);
         for (int i = 0; i < 4; i++) data_a[i] = 8'($urandom);
         r = $urandom_range(0, 2 * n + 1);
         run_and_check($sformatf("rnd%0d", k), 7'($urandom), n, (r <= n) ? r : -1, 0, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
